// File: rtl/fc_pkg.sv
// fc_pkg: shared types, constants and helpers for the FC argmax engine.
// FSM state enum, default score width, MOST_NEG, popcount and clog2.
package fc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DATA_W_DEF = 32;

  // Bit pattern of the most negative w-bit two's complement value.
  function automatic logic [63:0] MOST_NEG(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fc_lane_max.sv
// fc_lane_max: combinational max/index reduction over one LANES-wide beat.
// In: data, keep, base (index of first kept lane), limit. Out: beat_val, beat_idx, hit.
module fc_lane_max
  import fc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = 4,
  parameter int EW     = 5
) (
  input  logic [LANES*DATA_W-1:0] data,
  input  logic [LANES-1:0]        keep,
  input  logic [EW-1:0]           base,
  input  logic [EW-1:0]           limit,
  output logic [DATA_W-1:0]       beat_val,
  output logic [EW-1:0]           beat_idx,
  output logic                    hit
);

  localparam logic [DATA_W-1:0] NEG = DATA_W'(MOST_NEG(DATA_W));

  logic [EW-1:0]     rank;
  logic [DATA_W-1:0] v;

  // Lanes are visited lowest first, so a strict compare keeps the lower index on ties.
  always_comb begin
    beat_val = NEG;
    beat_idx = '0;
    hit      = 1'b0;
    rank     = base;
    v        = '0;
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        v = data[i*DATA_W +: DATA_W];
        if (rank < limit &&
            (!hit || $signed(v) > $signed(beat_val))) begin
          hit      = 1'b1;
          beat_val = v;
          beat_idx = rank;
        end
        rank = rank + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_argmax_stream.sv
// fc_argmax_stream: streaming signed argmax over NUM_CLASSES scores, LANES per beat.
// Ports: clk, rst, start, s_t* stream in; busy, done, max_idx, max_val, err_len,
// clk_counter out. Macro FC_ARGMAX_TOP2_EN adds runner-up outputs sec_idx, sec_val.
module fc_argmax_stream
  import fc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LANES       = 4,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 32,
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [LANES*DATA_W-1:0] s_tdata,
  input  logic [LANES-1:0]        s_tkeep,
  input  logic                    s_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        max_idx,
  output logic [DATA_W-1:0]       max_val,
  output logic                    err_len,
`ifdef FC_ARGMAX_TOP2_EN
  output logic [IDX_W-1:0]        sec_idx,
  output logic [DATA_W-1:0]       sec_val,
`endif
  output logic [CNT_W-1:0]        clk_counter
);

  // Element count clamps at NUM_CLASSES+1: any overrun is already a length error.
  localparam int EW = clog2(NUM_CLASSES + LANES + 2);
  localparam logic [EW-1:0] LIMIT = EW'(NUM_CLASSES);
  localparam logic [EW-1:0] SAT = EW'(NUM_CLASSES + 1);
  localparam logic [DATA_W-1:0] NEG = DATA_W'(MOST_NEG(DATA_W));

  state_t state, state_nxt;

  logic [DATA_W-1:0] best_val, beat_val, new_val;
  logic [IDX_W-1:0]  best_idx, new_idx;
  logic [EW-1:0]     elem_cnt, pop, sum, cnt_nxt, beat_idx;
  logic              hit, accept, take;

  fc_lane_max #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .EW    (EW)
  ) u_lane_max (
    .data    (s_tdata),
    .keep    (s_tkeep),
    .base    (elem_cnt),
    .limit   (LIMIT),
    .beat_val(beat_val),
    .beat_idx(beat_idx),
    .hit     (hit)
  );

  assign busy     = (state == RUN);
  assign s_tready = (state == RUN);
  assign done     = (state == DONE);
  assign accept   = (state == RUN) && s_tvalid;

  assign pop     = EW'(popcount(64'(s_tkeep)));
  assign sum     = elem_cnt + pop;
  assign cnt_nxt = (sum > SAT) ? SAT : sum;

  assign take    = hit && ($signed(beat_val) > $signed(best_val));
  assign new_val = take ? beat_val : best_val;
  assign new_idx = take ? IDX_W'(beat_idx) : best_idx;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && s_tlast) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      best_val    <= '0;
      best_idx    <= '0;
      elem_cnt    <= '0;
      max_val     <= '0;
      max_idx     <= '0;
      err_len     <= 1'b0;
      clk_counter <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        best_val    <= NEG;
        best_idx    <= '0;
        elem_cnt    <= '0;
        err_len     <= 1'b0;
        clk_counter <= '0;
      end
      if ((state == RUN || state == DONE) && clk_counter != '1)
        clk_counter <= clk_counter + 1'b1;
      if (accept) begin
        best_val <= new_val;
        best_idx <= new_idx;
        elem_cnt <= cnt_nxt;
        if (s_tlast) begin
          max_val <= new_val;
          max_idx <= new_idx;
          err_len <= (cnt_nxt != LIMIT);
        end
      end
    end
  end

`ifdef FC_ARGMAX_TOP2_EN
  logic [DATA_W-1:0] sec_run_val, t_mv, t_sv, t_v;
  logic [IDX_W-1:0]  sec_run_idx, t_mi, t_si;
  logic [EW-1:0]     t_rank;

  // Walk the beat in index order: a new max demotes the old max to second.
  always_comb begin
    t_mv   = best_val;
    t_mi   = best_idx;
    t_sv   = sec_run_val;
    t_si   = sec_run_idx;
    t_rank = elem_cnt;
    t_v    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s_tkeep[i]) begin
        t_v = s_tdata[i*DATA_W +: DATA_W];
        if (t_rank < LIMIT) begin
          if ($signed(t_v) > $signed(t_mv)) begin
            t_sv = t_mv;
            t_si = t_mi;
            t_mv = t_v;
            t_mi = IDX_W'(t_rank);
          end else if ($signed(t_v) > $signed(t_sv)) begin
            t_sv = t_v;
            t_si = IDX_W'(t_rank);
          end
        end
        t_rank = t_rank + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_run_val <= '0;
      sec_run_idx <= '0;
      sec_val     <= '0;
      sec_idx     <= '0;
    end else if (state == IDLE && start) begin
      sec_run_val <= NEG;
      sec_run_idx <= '0;
    end else if (accept) begin
      sec_run_val <= t_sv;
      sec_run_idx <= t_si;
      if (s_tlast) begin
        sec_val <= t_sv;
        sec_idx <= t_si;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_argmax_stream.sv
// tb_fc_argmax_stream: directed and randomized checks of fc_argmax_stream
// against a list-based argmax reference model.
module tb_fc_argmax_stream;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int NC = 10;
  localparam int CW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic [LN*DW-1:0] s_tdata = '0;
  logic [LN-1:0] s_tkeep = '0;
  logic s_tready, busy, done, err_len;
  logic [IW-1:0] max_idx;
  logic [DW-1:0] max_val;
  logic [CW-1:0] clk_counter;
`ifdef FC_ARGMAX_TOP2_EN
  logic [IW-1:0] sec_idx;
  logic [DW-1:0] sec_val;
`endif

  fc_argmax_stream #(
    .DATA_W(DW), .LANES(LN), .NUM_CLASSES(NC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .busy(busy), .done(done),
    .max_idx(max_idx), .max_val(max_val), .err_len(err_len),
`ifdef FC_ARGMAX_TOP2_EN
    .sec_idx(sec_idx), .sec_val(sec_val),
`endif
    .clk_counter(clk_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    keep;
    logic             last;
    int               gap;
  } beat_t;

  beat_t bq[$];
  int passed = 0;
  int total = 0;
  int cyc;
  int poke_at = -1;
  logic d1, d2, rdy_bad;
  int e_idx;
  logic [DW-1:0] e_val;
  logic e_err;

  // Reference: flatten kept lanes into an element list, argmax over the
  // first NC entries, first occurrence of the maximum wins.
  task automatic model();
    int vals[$];
    int n, mx;
    foreach (bq[b])
      for (int l = 0; l < LN; l++)
        if (bq[b].keep[l]) vals.push_back(int'(bq[b].data[l*DW +: DW]));
    n = (vals.size() < NC) ? vals.size() : NC;
    e_err = (vals.size() != NC);
    e_idx = 0;
    e_val = 32'h8000_0000;
    if (n > 0) begin
      mx = vals[0];
      for (int i = 1; i < n; i++) if (vals[i] > mx) mx = vals[i];
      for (int i = n - 1; i >= 0; i--) if (vals[i] == mx) e_idx = i;
      e_val = mx;
    end
  endtask

  task automatic pack(input int v[$], input int gap);
    beat_t bt;
    bq.delete();
    for (int i = 0; i < v.size(); i += LN) begin
      bt.data = {LN{32'h7FFF_0000}};
      bt.keep = '0;
      for (int l = 0; l < LN; l++)
        if (i + l < v.size()) begin
          bt.data[l*DW +: DW] = v[i+l];
          bt.keep[l] = 1'b1;
        end
      bt.last = (i + LN >= v.size());
      bt.gap = gap;
      bq.push_back(bt);
    end
  endtask

  task automatic drive_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    rdy_bad = 1'b0;
    foreach (bq[b]) begin
      repeat (bq[b].gap) begin
        s_tvalid = 1'b0;
        start = (poke_at == b);
        @(posedge clk); cyc++; #1 start = 1'b0;
      end
      s_tvalid = 1'b1;
      s_tdata = bq[b].data;
      s_tkeep = bq[b].keep;
      s_tlast = bq[b].last;
      start = (poke_at == b);
      if (s_tready !== 1'b1) rdy_bad = 1'b1;
      @(posedge clk); cyc++; #1 start = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tkeep = '0;
    @(negedge clk) d1 = done;
    @(posedge clk); #1;
    @(negedge clk) d2 = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, s_tready, done, err_len, max_idx, max_val, clk_counter} !== '0)
      $display("FAIL reset_hold: busy=%b rdy=%b done=%b err=%b idx=%0d val=%0d cnt=%0d, required all 0",
               busy, s_tready, done, err_len, max_idx, max_val, clk_counter);
    else passed++;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, clk_counter} !== '0)
      $display("FAIL reset_idle: busy=%b done=%b cnt=%0d, required 0", busy, done, clk_counter);
    else passed++;
  endtask

  task automatic test_basic(input int gap, input int poke);
    int q[$];
    int a[10];
    a = '{3, -1, 7, 2, 0, 7, -5, 9, 9, 1};
    foreach (a[i]) q.push_back(a[i]);
    pack(q, gap);
    poke_at = poke;
    drive_pass();
    poke_at = -1;
    total++;
    if (max_idx !== 4'd7 || max_val !== 32'd9 || err_len !== 1'b0)
      $display("FAIL basic_g%0d result: idx=%0d val=%0d err=%b, required idx=7 val=9 err=0",
               gap, max_idx, $signed(max_val), err_len);
    else passed++;
    total++;
    if (clk_counter !== 32'(cyc + 1))
      $display("FAIL basic_g%0d counter: got %0d, required %0d", gap, clk_counter, cyc + 1);
    else passed++;
    total++;
    if ({d1, d2, rdy_bad} !== 3'b100)
      $display("FAIL basic_g%0d done_pulse: done=%b,%b rdy_bad=%b, required 1,0 and 0",
               gap, d1, d2, rdy_bad);
    else passed++;
  endtask

  task automatic test_extremes();
    int q[$];
    q.push_back(-5);
    for (int i = 1; i < NC; i++) q.push_back(int'(32'h8000_0000));
    pack(q, 0);
    drive_pass();
    total++;
    if (max_idx !== 4'd0 || max_val !== 32'hFFFF_FFFB || err_len !== 1'b0)
      $display("FAIL extreme_neg: idx=%0d val=%0d err=%b, required idx=0 val=-5 err=0",
               max_idx, $signed(max_val), err_len);
    else passed++;
    q.delete();
    for (int i = 0; i < NC; i++) q.push_back(5);
    pack(q, 1);
    drive_pass();
    total++;
    if (max_idx !== 4'd0 || max_val !== 32'd5 || err_len !== 1'b0)
      $display("FAIL all_equal: idx=%0d val=%0d err=%b, required idx=0 val=5 err=0",
               max_idx, $signed(max_val), err_len);
    else passed++;
    total++;
    if (clk_counter !== 32'(cyc + 1))
      $display("FAIL all_equal counter: got %0d, required %0d", clk_counter, cyc + 1);
    else passed++;
  endtask

  task automatic test_length();
    int q[$];
    int a[8];
    int b[12];
    a = '{2, 9, 4, 9, 1, 0, 3, 8};
    foreach (a[i]) q.push_back(a[i]);
    pack(q, 0);
    drive_pass();
    total++;
    if (max_idx !== 4'd1 || max_val !== 32'd9 || err_len !== 1'b1)
      $display("FAIL short8: idx=%0d val=%0d err=%b, required idx=1 val=9 err=1",
               max_idx, $signed(max_val), err_len);
    else passed++;
    q.delete();
    b = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 4, 50, 60};
    foreach (b[i]) q.push_back(b[i]);
    pack(q, 0);
    drive_pass();
    total++;
    if (max_idx !== 4'd8 || max_val !== 32'd9 || err_len !== 1'b1)
      $display("FAIL long12: idx=%0d val=%0d err=%b, required idx=8 val=9 err=1",
               max_idx, $signed(max_val), err_len);
    else passed++;
  endtask

  task automatic test_empty();
    beat_t bt;
    bq.delete();
    bt.data = {LN{32'h0000_0040}};
    bt.keep = '0;
    bt.last = 1'b1;
    bt.gap = 0;
    bq.push_back(bt);
    drive_pass();
    total++;
    if (max_idx !== 4'd0 || max_val !== 32'h8000_0000 || err_len !== 1'b1)
      $display("FAIL empty: idx=%0d val=%h err=%b, required idx=0 val=80000000 err=1",
               max_idx, max_val, err_len);
    else passed++;
    total++;
    if (clk_counter !== 32'd2 || {d1, d2} !== 2'b10)
      $display("FAIL empty timing: cnt=%0d done=%b,%b, required cnt=2 done=1,0",
               clk_counter, d1, d2);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int q[$];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = {LN{32'd100}};
    s_tkeep = '1;
    s_tlast = 1'b0;
    @(posedge clk); #1 s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, s_tready, done, err_len, max_idx, max_val, clk_counter} !== '0)
      $display("FAIL reset_mid: busy=%b rdy=%b idx=%0d val=%0d cnt=%0d, required all 0",
               busy, s_tready, max_idx, max_val, clk_counter);
    else passed++;
    for (int i = 1; i <= NC; i++) q.push_back(i);
    pack(q, 0);
    drive_pass();
    total++;
    if (max_idx !== 4'd9 || max_val !== 32'd10 || err_len !== 1'b0)
      $display("FAIL after_reset: idx=%0d val=%0d err=%b, required idx=9 val=10 err=0",
               max_idx, $signed(max_val), err_len);
    else passed++;
  endtask

  task automatic test_random();
    beat_t bt;
    int nb, r;
    for (int p = 0; p < 30; p++) begin
      bq.delete();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int l = 0; l < LN; l++) begin
          r = $urandom_range(0, 19);
          if (r == 0) bt.data[l*DW +: DW] = 32'h8000_0000;
          else if (r == 1) bt.data[l*DW +: DW] = 32'h7FFF_FFFF;
          else bt.data[l*DW +: DW] = 32'(int'($urandom_range(0, 12)) - 6);
        end
        bt.keep = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        bt.gap = $urandom_range(0, 2);
        bt.last = (b == nb - 1);
        bq.push_back(bt);
      end
      poke_at = $urandom_range(0, nb);
      model();
      drive_pass();
      poke_at = -1;
      total++;
      if (max_idx !== e_idx[IW-1:0] || max_val !== e_val || err_len !== e_err)
        $display("FAIL rand%0d: idx=%0d val=%0d err=%b, required idx=%0d val=%0d err=%b",
                 p, max_idx, $signed(max_val), err_len, e_idx, $signed(e_val), e_err);
      else passed++;
      total++;
      if (clk_counter !== 32'(cyc + 1) || {d1, d2, rdy_bad} !== 3'b100)
        $display("FAIL rand%0d timing: cnt=%0d done=%b,%b rdy_bad=%b, required cnt=%0d done=1,0",
                 p, clk_counter, d1, d2, rdy_bad, cyc + 1);
      else passed++;
    end
  endtask

`ifdef FC_ARGMAX_TOP2_EN
  task automatic test_top2();
    int q[$];
    int a[10];
    a = '{4, 8, 8, 6, 1, 2, 3, 0, 5, 7};
    foreach (a[i]) q.push_back(a[i]);
    pack(q, 0);
    drive_pass();
    total++;
    if (max_idx !== 4'd1 || sec_idx !== 4'd2 || sec_val !== 32'd8)
      $display("FAIL top2: max_idx=%0d sec_idx=%0d sec_val=%0d, required 1, 2, 8",
               max_idx, sec_idx, $signed(sec_val));
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0, -1);
    test_basic(3, 1);
    test_extremes();
    test_length();
    test_empty();
    test_reset_mid();
    test_random();
`ifdef FC_ARGMAX_TOP2_EN
    test_top2();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
